// File: rtl/button_scan_ctrl.sv
// button_scan_ctrl: debounce scheduler sharing one stability counter across
// NUM_BUTTONS raw key inputs, scanned round-robin, with a small event FIFO.
// Optional feature macro: BTN_RELEASE_EVENTS_EN
//   defined     -> both press and release commits queue events
//   not defined -> only press commits queue events, event_pressed is tied to 1
module button_scan_ctrl #(
  parameter int NUM_BUTTONS  = 4,
  parameter int DELAY_COUNTS = 2500,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_BUTTONS-1:0]         buttons,
  output logic [NUM_BUTTONS-1:0]         button_state,
  output logic                           event_valid,
  input  logic                           event_ready,
  output logic [$clog2(NUM_BUTTONS)-1:0] event_id,
  output logic                           event_pressed,
  output logic                           overflow
);

  localparam int PTR_W = $clog2(NUM_BUTTONS);
  localparam int CNT_W = $clog2(DELAY_COUNTS);
  localparam int AW    = $clog2(FIFO_DEPTH);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_BUTTONS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_COUNTS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [AW:0]      FIFO_ONE = (AW + 1)'(1);

  typedef enum logic [1:0] {
    SCAN    = 2'd0,
    MEASURE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t                 state;
  logic [NUM_BUTTONS-1:0] sync_meta;
  logic [NUM_BUTTONS-1:0] sync;
  logic [PTR_W-1:0]       ptr;
  logic [PTR_W-1:0]       ptr_next;
  logic [CNT_W-1:0]       cnt;
  logic                   cand;

  logic                   push_req;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic [AW:0]            wr_ptr;
  logic [AW:0]            rd_ptr;
  logic [PTR_W-1:0]       id_mem [FIFO_DEPTH];
`ifdef BTN_RELEASE_EVENTS_EN
  logic                   pressed_mem [FIFO_DEPTH];
`endif

  // Two-flop synchroniser per raw key; everything downstream sees only sync.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= buttons;
      sync      <= sync_meta;
    end
  end

  assign ptr_next = (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;

  // Scheduler: scan for a mismatch, time the new level, then commit it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= SCAN;
      ptr          <= '0;
      cnt          <= '0;
      cand         <= 1'b0;
      button_state <= '0;
    end else begin
      unique case (state)
        SCAN: begin
          if (sync[ptr] == button_state[ptr]) begin
            ptr <= ptr_next;
          end else begin
            cand  <= sync[ptr];
            cnt   <= '0;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (sync[ptr] != cand) begin
            state <= SCAN;
            ptr   <= ptr_next;
          end else if (cnt == CNT_LAST) begin
            state <= COMMIT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        COMMIT: begin
          button_state[ptr] <= cand;
          ptr               <= ptr_next;
          state             <= SCAN;
        end
        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

  // A commit offers an event; releases only count when the feature is on.
`ifdef BTN_RELEASE_EVENTS_EN
  assign push_req = (state == COMMIT);
`else
  assign push_req = (state == COMMIT) && cand;
`endif

  // A full FIFO still accepts a push in the same cycle its head is popped.
  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop         = event_ready && !empty;
  assign push        = push_req && (!full || pop);
  assign event_valid = !empty;
  assign event_id    = id_mem[rd_ptr[AW-1:0]];
`ifdef BTN_RELEASE_EVENTS_EN
  assign event_pressed = pressed_mem[rd_ptr[AW-1:0]];
`else
  assign event_pressed = 1'b1;
`endif

  // Event storage; contents only matter between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr[AW-1:0]] <= ptr;
`ifdef BTN_RELEASE_EVENTS_EN
      pressed_mem[wr_ptr[AW-1:0]] <= cand;
`endif
    end
  end

  // FIFO pointers carry one extra wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_ONE;
      end
    end
  end

  // Sticky flag for an event lost to a full queue; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_req && full && !pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_button_scan_ctrl.sv
// tb_button_scan_ctrl: self-checking bench for button_scan_ctrl with
// NUM_BUTTONS=4, DELAY_COUNTS=8, FIFO_DEPTH=4. Follows BTN_RELEASE_EVENTS_EN.
`timescale 1ns/1ps
module tb_button_scan_ctrl;

  localparam int NB = 4;
  localparam int DC = 8;
  localparam int FD = 4;

`ifdef BTN_RELEASE_EVENTS_EN
  localparam bit RELEASE_EN = 1'b1;
`else
  localparam bit RELEASE_EN = 1'b0;
`endif

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic [NB-1:0] buttons     = '0;
  logic          event_ready = 1'b1;
  logic [NB-1:0] button_state;
  logic          event_valid;
  logic [1:0]    event_id;
  logic          event_pressed;
  logic          overflow;

  typedef struct packed {
    logic [1:0] id;
    logic       pressed;
  } evt_t;

  typedef struct {
    logic [NB-1:0] btn;
    int            hold;
    logic [NB-1:0] exp_state;
    string         name;
  } vec_t;

  evt_t exp_q[$];
  evt_t mon_e;
  int   errors = 0;
  int   checks = 0;

  button_scan_ctrl #(
    .NUM_BUTTONS (NB),
    .DELAY_COUNTS(DC),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .buttons      (buttons),
    .button_state (button_state),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .event_id     (event_id),
    .event_pressed(event_pressed),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endtask

  // Record an event the bench expects, honouring the release-event option.
  task automatic expectEvent(input int id, input logic pressed);
    evt_t e;
    if (pressed || RELEASE_EN) begin
      e.id      = 2'(id);
      e.pressed = pressed;
      exp_q.push_back(e);
    end
  endtask

  // Drive a button vector and let it sit for a number of cycles.
  task automatic applyStimulus(input logic [NB-1:0] btn, input int cycles);
    buttons = btn;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Three reset edges, checking outputs during reset; returns #1 after the last.
  task automatic applyReset(input logic [NB-1:0] btn);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    buttons     = btn;
    event_ready = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    checkOutput("reset_button_state", button_state, 0);
    checkOutput("reset_event_valid", event_valid, 0);
    checkOutput("reset_overflow", overflow, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput(name, exp_q.size(), 0);
  endtask

  // Scoreboard: every accepted event must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && event_valid === 1'b1 && event_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL event_order: got id=%0d pressed=%0b, required no event",
                 event_id, event_pressed);
      end else begin
        mon_e = exp_q.pop_front();
        if (event_id !== mon_e.id || event_pressed !== mon_e.pressed) begin
          errors++;
          $display("[TB] FAIL event_order: got id=%0d pressed=%0b, required id=%0d pressed=%0b",
                   event_id, event_pressed, mon_e.id, mon_e.pressed);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t          vecs[10];
    logic [NB-1:0] prev;
    int            rounds;
    int            queued;

    vecs[0] = '{4'b0101, 30, 4'b0101, "tbl_press0"};
    vecs[1] = '{4'b0111, 30, 4'b0111, "tbl_press1"};
    vecs[2] = '{4'b0011, 30, 4'b0011, "tbl_release2"};
    vecs[3] = '{4'b1011,  4, 4'b0011, "tbl_glitch3_high"};
    vecs[4] = '{4'b0011, 30, 4'b0011, "tbl_glitch3_after"};
    vecs[5] = '{4'b0001, 30, 4'b0001, "tbl_release1"};
    vecs[6] = '{4'b1001, 30, 4'b1001, "tbl_press3"};
    vecs[7] = '{4'b1000,  6, 4'b1001, "tbl_glitch0_low"};
    vecs[8] = '{4'b1001, 30, 4'b1001, "tbl_glitch0_after"};
    vecs[9] = '{4'b1000, 30, 4'b1000, "tbl_release0"};

    // Reset with all keys held: the synchronisers expose the levels just as
    // the scan reaches index 2, so presses commit in the order 2,3,0,1.
    $display("[TB] reset with all buttons held");
    applyReset(4'b1111);
    expectEvent(2, 1'b1);
    expectEvent(3, 1'b1);
    expectEvent(0, 1'b1);
    expectEvent(1, 1'b1);
    applyStimulus(4'b1111, 80);
    checkOutput("reset_all_state", button_state, 4'b1111);
    checkOutput("reset_all_overflow", overflow, 0);
    waitDrain("reset_all_drain");

    // Clean press with ptr landing on button 2 at detection: 12-cycle latency.
    $display("[TB] clean press latency");
    applyReset(4'b0000);
    expectEvent(2, 1'b1);
    buttons = 4'b0100;
    repeat (11) @(posedge clk);
    #1;
    checkOutput("press_before_latency", button_state, 4'b0000);
    @(posedge clk);
    #1;
    checkOutput("press_at_latency", button_state, 4'b0100);
    checkOutput("press_event_valid", event_valid, 1);
    checkOutput("press_event_id", event_id, 2);
    checkOutput("press_event_pressed", event_pressed, 1);
    waitDrain("press_drain");

    // Short glitch on button 1 must not commit anything.
    $display("[TB] glitch rejection");
    applyStimulus(4'b0110, 5);
    applyStimulus(4'b0100, 40);
    checkOutput("glitch_state", button_state, 4'b0100);
    checkOutput("glitch_no_event", event_valid, 0);

    // Table of single-key changes and short glitches.
    $display("[TB] table-driven sequence");
    prev = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      for (int b = 0; b < NB; b++) begin
        if (vecs[i].exp_state[b] != prev[b]) begin
          expectEvent(b, vecs[i].exp_state[b]);
        end
      end
      applyStimulus(vecs[i].btn, vecs[i].hold);
      checkOutput(vecs[i].name, button_state, vecs[i].exp_state);
      prev = vecs[i].exp_state;
    end
    waitDrain("table_drain");

    // All keys pressed together with ptr at 1: events follow scan order 1,2,3,0.
    $display("[TB] simultaneous presses");
    applyReset(4'b0000);
    applyStimulus(4'b0000, 3);
    expectEvent(1, 1'b1);
    expectEvent(2, 1'b1);
    expectEvent(3, 1'b1);
    expectEvent(0, 1'b1);
    applyStimulus(4'b1111, 60);
    checkOutput("simul_state", button_state, 4'b1111);
    waitDrain("simul_drain");

    // Backpressure: more events than FIFO entries while the consumer stalls.
    $display("[TB] backpressure and overflow");
    applyReset(4'b0000);
    event_ready = 1'b0;
    rounds = RELEASE_EN ? 3 : 5;
    queued = 0;
    for (int r = 0; r < rounds; r++) begin
      if (queued < FD) begin
        expectEvent(0, 1'b1);
        queued++;
      end
      applyStimulus(4'b0001, 30);
      if (r == 0) begin
        checkOutput("bp_head_valid", event_valid, 1);
        checkOutput("bp_head_id", event_id, 0);
        checkOutput("bp_head_pressed", event_pressed, 1);
      end
      if (RELEASE_EN && queued < FD) begin
        expectEvent(0, 1'b0);
        queued++;
      end
      applyStimulus(4'b0000, 30);
    end
    checkOutput("bp_state", button_state, 4'b0000);
    checkOutput("bp_overflow", overflow, 1);
    checkOutput("bp_held_id", event_id, 0);
    checkOutput("bp_held_pressed", event_pressed, 1);
    event_ready = 1'b1;
    waitDrain("bp_drain");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_empty_after", event_valid, 0);
    checkOutput("bp_overflow_sticky", overflow, 1);

    // Press then release button 3: release is silent unless the option is on.
    $display("[TB] press and release button 3");
    applyReset(4'b0000);
    expectEvent(3, 1'b1);
    applyStimulus(4'b1000, 30);
    checkOutput("b3_pressed_state", button_state, 4'b1000);
    expectEvent(3, 1'b0);
    applyStimulus(4'b0000, 30);
    checkOutput("b3_released_state", button_state, 4'b0000);
    waitDrain("b3_drain");
    repeat (5) @(posedge clk);
    #1;
    checkOutput("b3_no_extra_event", event_valid, 0);
    checkOutput("b3_overflow", overflow, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
